fp_div_seq: RTL and testbench

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_div_seq.sv | 168 ++++++++++++++++
 tb/tb_fp_div_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// fp_div_seq -- sequential floating-point divider (fp32 or fp16, truncating).
//
// Mantissas are divided by restoring division, one quotient bit per DIV cycle.
// A NORM cycle normalizes, packs and range-checks the result. Special operands
// (NaN/Inf exponent, zero or denormal inputs) bypass the datapath and reach
// DONE one cycle after start.
//
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   start     : request a division (sampled only in IDLE)
//   a, b      : dividend, divisor (fp32 on [31:0], fp16 on [15:0])
//   sel       : 0 = fp32, 1 = fp16
//   result    : quotient, fp16 zero-extended; held until the next DONE
//   FPUFlags  : {N, Z, 2'b00}
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse when result/FPUFlags are valid
module fp_div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sel,
  output logic [31:0] result,
  output logic [3:0]  FPUFlags,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t state, state_nx;

  // Captured operation state
  logic               sel_r;
  logic               sgn_r;
  logic [4:0]         cnt;
  logic [24:0]        rem;     // always < 2*mb, fits 25 bits
  logic [23:0]        mb;
  logic [24:0]        q;       // fp32: q[24:0]; fp16: q[11:0]
  logic signed [9:0]  e_r;

  // ---------------- input field decode ----------------
  logic [7:0]  ea, eb, emax_in;
  logic [23:0] ma, mb_in;
  logic        sa, sb, a_zero, b_zero, special;
  logic [31:0] spec_res;

  always_comb begin
    ea      = sel ? {3'b0, a[14:10]} : a[30:23];
    eb      = sel ? {3'b0, b[14:10]} : b[30:23];
    emax_in = sel ? 8'd31 : 8'd255;
    sa      = sel ? a[15] : a[31];
    sb      = sel ? b[15] : b[31];
    ma      = sel ? {13'b0, 1'b1, a[9:0]} : {1'b1, a[22:0]};
    mb_in   = sel ? {13'b0, 1'b1, b[9:0]} : {1'b1, b[22:0]};
    // a zero exponent field covers both true zero and denormals
    a_zero  = (ea == 8'd0);
    b_zero  = (eb == 8'd0);
    special = (ea == emax_in) || (eb == emax_in) || a_zero || b_zero;

    spec_res = 32'h0;
    if ((ea == emax_in) || (eb == emax_in) || (a_zero && b_zero))
      spec_res = sel ? 32'h0000_7E00 : 32'h7FC0_0000;
    else if (b_zero)
      spec_res = sel ? {16'b0, sa ^ sb, 15'h7C00} : {sa ^ sb, 31'h7F80_0000};
    else
      spec_res = 32'h0;
  end

  // ---------------- division step ----------------
  logic        ge;
  logic [24:0] diff;

  always_comb begin
    ge   = (rem >= {1'b0, mb});
    diff = rem - {1'b0, mb};
  end

  // ---------------- normalize / pack ----------------
  logic               q_msb;
  logic signed [9:0]  e_n, emax_r;
  logic [22:0]        frac32;
  logic [9:0]         frac16;
  logic [31:0]        norm_res;

  always_comb begin
    q_msb  = sel_r ? q[11] : q[24];
    e_n    = q_msb ? e_r : e_r - 10'sd1;
    frac32 = q_msb ? q[23:1] : q[22:0];
    frac16 = q_msb ? q[10:1] : q[9:0];
    emax_r = sel_r ? 10'sd31 : 10'sd255;

    if (e_n >= emax_r)
      norm_res = sel_r ? {16'b0, sgn_r, 5'h1F, 10'b0} : {sgn_r, 8'hFF, 23'b0};
    else if (e_n <= 10'sd0)
      norm_res = 32'h0;
    else
      norm_res = sel_r ? {16'b0, sgn_r, e_n[4:0], frac16} : {sgn_r, e_n[7:0], frac32};
  end

  function automatic logic [3:0] mk_flags(input logic [31:0] r, input logic s16);
    mk_flags = {(s16 ? r[15] : r[31]), (r == 32'h0), 2'b00};
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE: if (start) state_nx = special ? DONE : DIV;
      // last iteration runs in the cycle that leaves DIV
      DIV:  if (cnt == (sel_r ? 5'd11 : 5'd24)) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_r    <= 1'b0;
      sgn_r    <= 1'b0;
      cnt      <= 5'd0;
      rem      <= 25'd0;
      mb       <= 24'd0;
      q        <= 25'd0;
      e_r      <= 10'sd0;
      result   <= 32'h0;
      FPUFlags <= 4'h0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sel_r <= sel;
          sgn_r <= sa ^ sb;
          cnt   <= 5'd0;
          rem   <= {1'b0, ma};
          mb    <= mb_in;
          q     <= 25'd0;
          e_r   <= $signed({2'b0, ea}) - $signed({2'b0, eb}) + (sel ? 10'sd15 : 10'sd127);
          if (special) begin
            result   <= spec_res;
            FPUFlags <= mk_flags(spec_res, sel);
          end
        end
        DIV: begin
          cnt <= cnt + 5'd1;
          q   <= {q[23:0], ge};
          rem <= ge ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};
        end
        NORM: begin
          result   <= norm_res;
          FPUFlags <= mk_flags(norm_res, sel_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        reset, start, sel;
  logic [31:0] a, b, result;
  logic [3:0]  FPUFlags;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  fp_div_seq dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sel(sel),
    .result(result), .FPUFlags(FPUFlags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive operands at a negedge, let the next posedge sample them, then
  // scramble the inputs so a late-capture bug would show.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
    reset = 1'b0;
    a = ta; b = tb_; sel = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sel = ~ts;
  endtask

  // Latency n = done seen at the n-th negedge after the start edge.
  task automatic wait_done(input int restart_cyc, output int lat, output logic busy_ok);
    lat = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == restart_cyc) begin
        start = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000; sel = 1'b0;
      end else start = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic ts, input logic [31:0] er, input logic [3:0] ef,
                       input int el, input int rc);
    int   lat;
    logic bok;
    @(negedge clk);
    launch(ta, tb_, ts);
    wait_done(rc, lat, bok);
    chk({tag, "_lat"},  32'(lat), 32'(el));
    chk({tag, "_res"},  result, er);
    chk({tag, "_flg"},  {28'b0, FPUFlags}, {28'b0, ef});
    chk({tag, "_busy"}, {31'b0, bok}, 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, result, er);
  endtask

  initial begin
    int   lat;
    logic bok, early;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res",  result, 32'h0);
    chk("rst_flg",  {28'b0, FPUFlags}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);

    // first start lands on the first edge with reset low
    do_op("f32_6d2",   32'h40C0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000, 27, 0);
    do_op("f32_1dm4",  32'h3F80_0000, 32'hC080_0000, 1'b0, 32'hBE80_0000, 4'b1000, 27, 0);
    do_op("f32_1d3",   32'h3F80_0000, 32'h4040_0000, 1'b0, 32'h3EAA_AAAA, 4'b0000, 27, 0);
    do_op("f16_1dh",   32'h0000_3C00, 32'h0000_3800, 1'b1, 32'h0000_4000, 4'b0000, 14, 0);
    do_op("f16_upper", 32'hFFFF_3C00, 32'hFFFF_3800, 1'b1, 32'h0000_4000, 4'b0000, 14, 0);
    do_op("f16_1d3",   32'h0000_3C00, 32'h0000_4200, 1'b1, 32'h0000_3555, 4'b0000, 14, 0);
    do_op("sp_bzero",  32'h3F80_0000, 32'h0000_0000, 1'b0, 32'h7F80_0000, 4'b0000, 1, 0);
    do_op("sp_00",     32'h0000_0000, 32'h0000_0000, 1'b0, 32'h7FC0_0000, 4'b0000, 1, 0);
    do_op("sp_azero",  32'h0000_0000, 32'h4000_0000, 1'b0, 32'h0000_0000, 4'b0100, 1, 0);
    do_op("sp_nan",    32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b0000, 1, 0);
    do_op("sp_denb",   32'h3F80_0000, 32'h0000_0001, 1'b0, 32'h7F80_0000, 4'b0000, 1, 0);
    do_op("sp16_binf", 32'h0000_BC00, 32'h0000_0000, 1'b1, 32'h0000_FC00, 4'b1000, 1, 0);
    do_op("sp16_nan",  32'h0000_7C00, 32'h0000_3C00, 1'b1, 32'h0000_7E00, 4'b0000, 1, 0);
    do_op("f32_ovf",   32'h7F00_0000, 32'h3E80_0000, 1'b0, 32'h7F80_0000, 4'b0000, 27, 0);
    do_op("f32_unf",   32'h8080_0000, 32'h4000_0000, 1'b0, 32'h0000_0000, 4'b0100, 27, 0);
    // start re-pulsed at cycle 5 must be ignored
    do_op("f32_restart", 32'h40C0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000, 27, 5);

    // reset mid-DIV, then immediate restart
    @(negedge clk);
    launch(32'h40C0_0000, 32'h4000_0000, 1'b0);
    early = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) early = 1'b1;
      if (n == 10) reset = 1'b1;
    end
    @(negedge clk);
    chk("mid_rst_nodone", {31'b0, early}, 32'd0);
    chk("mid_rst_busy",   {31'b0, busy}, 32'd0);
    chk("mid_rst_done",   {31'b0, done}, 32'd0);
    chk("mid_rst_res",    result, 32'h0);
    chk("mid_rst_flg",    {28'b0, FPUFlags}, 32'h0);
    launch(32'h3F80_0000, 32'hC080_0000, 1'b0);
    wait_done(0, lat, bok);
    chk("post_rst_lat", 32'(lat), 32'd27);
    chk("post_rst_res", result, 32'hBE80_0000);
    chk("post_rst_flg", {28'b0, FPUFlags}, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
